// File: rtl/alu_bist_sequencer_if.sv
// rtl/alu_bist_sequencer_if.sv - ALU operand/result bus between BIST sequencer and 3-bit ALU
interface alu_bist_sequencer_if;
  logic [2:0] alu_A;
  logic [2:0] alu_B;
  logic [2:0] alu_sel;
  logic [2:0] alu_result;
  logic       alu_carry_out;
  logic       alu_zero;
  logic       alu_equal;
  logic       alu_less_than;
  logic       alu_greater_than;

  // Sequencer side: drives operands, observes ALU outputs
  modport master (
    output alu_A, alu_B, alu_sel,
    input  alu_result, alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than
  );

  // ALU side: consumes operands, returns result and flags
  modport slave (
    input  alu_A, alu_B, alu_sel,
    output alu_result, alu_carry_out, alu_zero, alu_equal, alu_less_than, alu_greater_than
  );
endinterface

// File: rtl/alu_bist_sequencer.sv
// rtl/alu_bist_sequencer.sv - BIST driver sweeping all 512 {sel,B,A} ALU vectors (option: ALU_BIST_STOP_ON_FAIL_EN)
module alu_bist_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  alu_bist_sequencer_if.master        alu,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [9:0]                  fail_count,
  output logic [8:0]                  first_fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t      state_q;
  logic [8:0]  vec_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [9:0]  fail_q;
  logic [8:0]  ffv_q;

  logic [2:0]  op_a;
  logic [2:0]  op_b;
  logic [2:0]  op_sel;
  logic [3:0]  sum;
  logic [2:0]  gold_res;
  logic        gold_cy;
  logic [7:0]  golden;
  logic [7:0]  observed;
  logic        mismatch;
  logic [9:0]  fail_d;
  logic        settle_last;

  assign op_a   = vec_q[2:0];
  assign op_b   = vec_q[5:3];
  assign op_sel = vec_q[8:6];

  // Operands come straight from the vector register so the ALU sees glitch-free inputs
  assign alu.alu_A   = op_a;
  assign alu.alu_B   = op_b;
  assign alu.alu_sel = op_sel;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_vec = ffv_q;

  assign sum = {1'b0, op_a} + {1'b0, op_b};

  // Golden ALU: result and carry per opcode; carry only meaningful for ADD/SUB
  always_comb begin
    gold_res = 3'd0;
    gold_cy  = 1'b0;
    case (op_sel)
      3'd0: begin gold_res = sum[2:0];     gold_cy = sum[3];      end
      3'd1: begin gold_res = op_a - op_b;  gold_cy = (op_a < op_b); end
      3'd2: gold_res = op_a & op_b;
      3'd3: gold_res = op_a | op_b;
      3'd4: gold_res = op_a ^ op_b;
      3'd5: gold_res = ~op_a;
      3'd6: gold_res = {op_a[1:0], 1'b0};
      default: gold_res = {1'b0, op_a[2:1]};
    endcase
  end

  assign golden   = {gold_res, gold_cy, (gold_res == 3'd0), (op_a == op_b), (op_a < op_b), (op_a > op_b)};
  assign observed = {alu.alu_result, alu.alu_carry_out, alu.alu_zero, alu.alu_equal,
                     alu.alu_less_than, alu.alu_greater_than};
  assign mismatch    = (observed != golden);
  assign fail_d      = fail_q + {9'd0, mismatch};
  assign settle_last = (cnt_q == 4'(SETTLE_CYCLES - 1));

  // Run FSM: settle each vector, check once, advance; all outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 9'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 10'd0;
      ffv_q   <= 9'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_SETTLE;
            vec_q   <= 9'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 10'd0;
            ffv_q   <= 9'd0;
          end
        end
        S_SETTLE: begin
          if (settle_last) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_CHECK: begin
          fail_q <= fail_d;
          if (mismatch && (fail_q == 10'd0)) begin
            ffv_q <= vec_q;
          end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
          if (mismatch || (vec_q == 9'h1FF)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_d == 10'd0);
          end else begin
            vec_q   <= vec_q + 9'd1;
            cnt_q   <= 4'd0;
            state_q <= S_SETTLE;
          end
`else
          if (vec_q == 9'h1FF) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_d == 10'd0);
          end else begin
            vec_q   <= vec_q + 9'd1;
            cnt_q   <= 4'd0;
            state_q <= S_SETTLE;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// tb/tb_alu_bist_sequencer.sv - self-checking bench for alu_bist_sequencer with fault-injecting ALU model
module tb_alu_bist_sequencer;
  localparam int S       = 2;
  localparam int VEC_CYC = S + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [9:0] fail_count;
  logic [8:0] first_fail_vec;
  logic [7:0] alu_o;
  int         mode = 0;

  alu_bist_sequencer_if bus ();

  alu_bist_sequencer #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu(bus),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference ALU from arithmetic on integers: {result, carry, zero, equal, lt, gt}
  function automatic logic [7:0] ref_alu(int v);
    int a, b, sel, r, c;
    a = v & 7; b = (v >> 3) & 7; sel = (v >> 6) & 7; c = 0;
    case (sel)
      0: begin r = (a + b) & 7; c = ((a + b) > 7) ? 1 : 0; end
      1: begin r = (a - b) & 7; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & 7;
      6: r = (a * 2) & 7;
      default: r = a / 2;
    endcase
    return {r[2:0], c[0], (r == 0), (a == b), (a < b), (a > b)};
  endfunction

  // ALU under test: reference behaviour plus the fault selected by md
  function automatic logic [7:0] faulty_alu(int v, int md);
    logic [7:0] o;
    o = ref_alu(v);
    if (md == 1 && v == 'h087) o[7:5] = 3'b001;
    if (md == 2) o[4] = 1'b1;
    return o;
  endfunction

  always_comb alu_o = faulty_alu(int'({bus.alu_sel, bus.alu_B, bus.alu_A}), mode);
  assign bus.alu_result       = alu_o[7:5];
  assign bus.alu_carry_out    = alu_o[4];
  assign bus.alu_zero         = alu_o[3];
  assign bus.alu_equal        = alu_o[2];
  assign bus.alu_less_than    = alu_o[1];
  assign bus.alu_greater_than = alu_o[0];

  // Expected run outcome for the current mode
  int pre[0:512];
  int m_first, m_total, m_last, m_len;
  bit tracking = 1'b0;
  bit arm = 1'b0;
  int n = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_model();
    int cnt;
    cnt = 0; m_first = -1; m_last = 511;
    for (int v = 0; v < 512; v++) begin
      pre[v] = cnt;
      if (faulty_alu(v, mode) != ref_alu(v)) begin
        cnt++;
        if (m_first < 0) m_first = v;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        m_last = v;
        break;
`endif
      end
    end
    m_total = cnt;
    m_len   = (m_last + 1) * VEC_CYC;
  endtask

  // Per-cycle compare: outputs as a function of cycles elapsed since the start edge
  always @(negedge clk) begin
    int k;
    logic [30:0] act, exp;
    if (rst_n && tracking) begin
      if (arm) begin n = 0; arm = 1'b0; end else n++;
      act = {busy, done, pass, fail_count, first_fail_vec, bus.alu_sel, bus.alu_B, bus.alu_A};
      if (n < m_len) begin
        k = n / VEC_CYC;
        exp = {1'b1, 1'b0, 1'b0, 10'(pre[k]), (pre[k] > 0) ? 9'(m_first) : 9'd0, 9'(k)};
      end else begin
        exp = {1'b0, 1'b1, (m_total == 0), 10'(m_total), (m_total > 0) ? 9'(m_first) : 9'd0, 9'(m_last)};
      end
      chk("cycle", 32'(act), 32'(exp));
    end
  end

  task automatic pulse_start(bit track);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (track) begin
      build_model();
      arm = 1'b1;
      tracking = 1'b1;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(string name);
    chk(name, 32'({busy, done, pass, fail_count, first_fail_vec, bus.alu_sel, bus.alu_B, bus.alu_A}), 32'd0);
  endtask

  initial begin
    // Reset values while rst_n is low
    #7 chk_all_zero("reset_outputs");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_without_start", 32'({busy, done}), 32'd0);

    // Correct ALU; stray start mid-run must be ignored
    mode = 0;
    pulse_start(1'b1);
    repeat (498) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("good_pass", 32'(pass), 32'd1);
    chk("good_fail_count", 32'(fail_count), 32'd0);
    chk("good_len", 32'(m_len), 32'(512 * VEC_CYC));
    chk("good_len_literal", 32'(m_len), 32'd1536);

    // Single forced fault; start issued from DONE
    mode = 1;
    pulse_start(1'b1);
    wait_done();
    @(negedge clk);
    chk("one_fault_count", 32'(fail_count), 32'd1);
    chk("one_fault_vec", 32'(first_fail_vec), 32'h087);
    chk("one_fault_pass", 32'(pass), 32'd0);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    chk("stop_sel", 32'(bus.alu_sel), 32'd2);
    chk("stop_A", 32'(bus.alu_A), 32'd7);
`endif

    // Carry stuck at 1
    mode = 2;
    pulse_start(1'b1);
    wait_done();
    @(negedge clk);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    chk("carry_count", 32'(fail_count), 32'd1);
`else
    chk("carry_count", 32'(fail_count), 32'd456);
    chk("carry_model_total", 32'(m_total), 32'd456);
`endif
    chk("carry_first", 32'(first_fail_vec), 32'h000);
    chk("carry_pass", 32'(pass), 32'd0);

    // Asynchronous reset mid-run, asserted between clock edges
    mode = 0;
    pulse_start(1'b1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    tracking = 1'b0;
    #1 chk_all_zero("async_reset_midrun");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", 32'({busy, done, fail_count}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
